// File: rtl/seven_segment_scan_counter.sv
// seven_segment_scan_counter
// Multi-digit BCD seconds counter with a time-multiplexed common-cathode
// 7-segment display driver. Every state flop except the wrap pulse sits on one
// scan chain: div, digits, refresh, idx (scan_in side first).
// Build option: define DOWN_COUNT_EN to add the 'up' direction port; without it
// the counter is up-only.
module seven_segment_scan_counter #(
  parameter int DIGITS        = 4,
  parameter int DIV_MAX       = 9_999_999,
  parameter int DIV_WIDTH     = 24,
  parameter int REFRESH_WIDTH = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
`ifdef DOWN_COUNT_EN
  input  logic              up,
`endif
  input  logic              scan_in,
  input  logic              scan_en,
  output logic              scan_out,
  output logic [6:0]        led_out,
  output logic [DIGITS-1:0] digit_sel,
  output logic              wrap
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int DIG_W = 4 * DIGITS;
  localparam int L     = DIV_WIDTH + DIG_W + REFRESH_WIDTH + IDX_W;

  localparam logic [DIV_WIDTH-1:0] DIV_MAX_C = DIV_WIDTH'(DIV_MAX);
  localparam logic [IDX_W-1:0]     LAST_IDX  = IDX_W'(DIGITS - 1);
  localparam logic [IDX_W:0]       IDX_LIM   = (IDX_W + 1)'(DIGITS);

  // Scan-only values above 9 behave as 9 when a digit is updated.
  function automatic logic [3:0] clamp_bcd(input logic [3:0] v);
    return (v > 4'd9) ? 4'd9 : v;
  endfunction

  // Segment pattern {g,f,e,d,c,b,a}; non-decimal values are blanked.
  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'd0:    return 7'h3F;
      4'd1:    return 7'h06;
      4'd2:    return 7'h5B;
      4'd3:    return 7'h4F;
      4'd4:    return 7'h66;
      4'd5:    return 7'h6D;
      4'd6:    return 7'h7D;
      4'd7:    return 7'h07;
      4'd8:    return 7'h7F;
      4'd9:    return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  logic [DIV_WIDTH-1:0]     div_q, div_d;
  logic [DIG_W-1:0]         digits_q, digits_d;
  logic [REFRESH_WIDTH-1:0] ref_q, ref_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic                     wrap_q, wrap_d;
  logic                     tick;
  logic                     count_up;
  logic                     carry;
  logic [3:0]               cur, nxt;
  logic [L-1:0]             chain;

`ifdef DOWN_COUNT_EN
  assign count_up = up;
`else
  assign count_up = 1'b1;
`endif

  assign chain = {idx_q, ref_q, digits_q, div_q};

  // Seconds divider: counts only while enabled, tick on terminal count.
  always_comb begin
    tick  = 1'b0;
    div_d = div_q;
    if (ena) begin
      if (div_q == DIV_MAX_C) begin
        tick  = 1'b1;
        div_d = '0;
      end else begin
        div_d = div_q + 1'b1;
      end
    end
  end

  // BCD ripple: the tick enters digit 0 as carry/borrow; a carry out of the
  // top digit is exactly the all-9s->0s (or all-0s->9s) wrap.
  always_comb begin
    digits_d = digits_q;
    carry    = tick;
    cur      = 4'd0;
    nxt      = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        cur = clamp_bcd(digits_q[4*i +: 4]);
        if (count_up) begin
          if (cur == 4'd9) begin
            nxt   = 4'd0;
            carry = 1'b1;
          end else begin
            nxt   = cur + 4'd1;
            carry = 1'b0;
          end
        end else begin
          if (cur == 4'd0) begin
            nxt   = 4'd9;
            carry = 1'b1;
          end else begin
            nxt   = cur - 4'd1;
            carry = 1'b0;
          end
        end
        digits_d[4*i +: 4] = nxt;
      end
    end
    wrap_d = carry;
  end

  // Display refresh: free-running prescaler steps the active digit index.
  always_comb begin
    ref_d = ref_q + 1'b1;
    idx_d = idx_q;
    if (&ref_q) begin
      idx_d = (idx_q >= LAST_IDX) ? '0 : idx_q + 1'b1;
    end
  end

  // State update: reset, else scan shift, else functional next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q    <= '0;
      digits_q <= '0;
      ref_q    <= '0;
      idx_q    <= '0;
      wrap_q   <= 1'b0;
    end else if (scan_en) begin
      {idx_q, ref_q, digits_q, div_q} <= {chain[L-2:0], scan_in};
      wrap_q <= 1'b0;
    end else begin
      div_q    <= div_d;
      digits_q <= digits_d;
      ref_q    <= ref_d;
      idx_q    <= idx_d;
      wrap_q   <= wrap_d;
    end
  end

  // Digit select and segment decode for the active index; out-of-range blanks.
  always_comb begin
    digit_sel = '0;
    led_out   = 7'h00;
    if ({1'b0, idx_q} < IDX_LIM) begin
      digit_sel = DIGITS'(1) << idx_q;
      for (int i = 0; i < DIGITS; i++) begin
        if (idx_q == IDX_W'(i)) begin
          led_out = seg7(digits_q[4*i +: 4]);
        end
      end
    end
  end

  assign scan_out = idx_q[IDX_W-1];
  assign wrap     = wrap_q & ~scan_en;

endmodule
